pipe_operand_feeder: RTL

Sequencing front end of the convolution MAC pipeline. Reads input-feature (IF) and filter scratchpads and slides the filter window across the IF vector with a configurable stride. Emits one operand pair per cycle together with the load and partial-sum-boundary controls (`ld_mult`, `ld_add`, `par_done`) that the MAC datapath consumes. Honours `pipe_stall` from downstream and reports completion of the whole convolution.

---
 rtl/pipe_feeder_pkg.sv | 18 +
 rtl/window_addr_gen.sv | 66 ++++++
 rtl/pipe_operand_feeder.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_feeder_pkg.sv
// Shared types and default widths for the convolution operand feeder.
package pipe_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DEF_IF_CELL_SIZE      = 8;
    localparam int DEF_FILTER_CELL_SIZE  = 8;
    localparam int DEF_IF_ADDR_WIDTH     = 6;
    localparam int DEF_FILTER_ADDR_WIDTH = 4;
    localparam int DEF_STRIDE            = 1;
    localparam int STALL_CNT_WIDTH       = 16;

endpackage

// File: rtl/window_addr_gen.sv
// Sliding-window address generator: tap counter innermost, window base steps by STRIDE.
module window_addr_gen #(
    parameter int IF_ADDR_WIDTH     = 6,
    parameter int FILTER_ADDR_WIDTH = 4,
    parameter int STRIDE            = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         advance,
    input  logic [IF_ADDR_WIDTH:0]       if_len,
    input  logic [FILTER_ADDR_WIDTH:0]   filter_len,
    output logic [IF_ADDR_WIDTH-1:0]     if_raddr,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_raddr,
    output logic                         last_tap,
    output logic                         last_win
);

    localparam int IW = IF_ADDR_WIDTH + 1;
    localparam int FW = FILTER_ADDR_WIDTH + 1;
    localparam logic [IF_ADDR_WIDTH-1:0] STEP = IF_ADDR_WIDTH'(STRIDE);

    logic [FW-1:0]            tap;
    logic [FW-1:0]            tap_last;
    logic [IW-1:0]            win;
    logic [IW-1:0]            win_last;
    logic [IW-1:0]            span;
    logic [IF_ADDR_WIDTH-1:0] base;

    assign span         = if_len - IW'(filter_len);
    assign if_raddr     = base + IF_ADDR_WIDTH'(tap);
    assign filter_raddr = tap[FW-2:0];
    assign last_tap     = (tap == tap_last);
    assign last_win     = (win == win_last);

    // Counters return to zero after the final pair so idle addresses read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap      <= '0;
            tap_last <= '0;
            win      <= '0;
            win_last <= '0;
            base     <= '0;
        end else if (load) begin
            tap      <= '0;
            win      <= '0;
            base     <= '0;
            tap_last <= filter_len - FW'(1);
            win_last <= span / IW'(STRIDE);
        end else if (advance) begin
            if (!last_tap) begin
                tap <= tap + FW'(1);
            end else begin
                tap <= '0;
                if (last_win) begin
                    win  <= '0;
                    base <= '0;
                end else begin
                    win  <= win + IW'(1);
                    base <= base + STEP;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_operand_feeder.sv
// Operand sequencer for the conv MAC pipeline; optional stall counter under PIPE_FEEDER_STALL_CNT_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   ISSUE  | one scratchpad read per unstalled cycle
//   DRAIN  | final ld_mult / ld_add leaving the valid pipeline
//   FINISH | one-cycle done pulse
module pipe_operand_feeder
    import pipe_feeder_pkg::*;
#(
    parameter int IF_CELL_SIZE      = DEF_IF_CELL_SIZE,
    parameter int FILTER_CELL_SIZE  = DEF_FILTER_CELL_SIZE,
    parameter int IF_ADDR_WIDTH     = DEF_IF_ADDR_WIDTH,
    parameter int FILTER_ADDR_WIDTH = DEF_FILTER_ADDR_WIDTH,
    parameter int STRIDE            = DEF_STRIDE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [IF_ADDR_WIDTH:0]       if_len,
    input  logic [FILTER_ADDR_WIDTH:0]   filter_len,
    input  logic                         pipe_stall,
    output logic [IF_ADDR_WIDTH-1:0]     if_raddr,
    output logic                         if_ren,
    input  logic [IF_CELL_SIZE-1:0]      if_rdata,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_raddr,
    output logic                         filter_ren,
    input  logic [FILTER_CELL_SIZE-1:0]  filter_rdata,
    output logic [IF_CELL_SIZE-1:0]      if_out,
    output logic [FILTER_CELL_SIZE-1:0]  filter_out,
    output logic                         ld_mult,
    output logic                         ld_add,
    output logic                         par_done,
    output logic                         busy,
    output logic                         done
`ifdef PIPE_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
`endif
);

    state_t state;
    logic   v1;
    logic   v2;
    logic   par1;
    logic   issue;
    logic   accept;
    logic   degenerate;
    logic   last_tap;
    logic   last_win;

    assign issue      = (state == ISSUE) && !pipe_stall;
    assign accept     = (state == IDLE) && start;
    assign degenerate = (filter_len == '0) || (if_len < (IF_ADDR_WIDTH + 1)'(filter_len));

    window_addr_gen #(
        .IF_ADDR_WIDTH    (IF_ADDR_WIDTH),
        .FILTER_ADDR_WIDTH(FILTER_ADDR_WIDTH),
        .STRIDE           (STRIDE)
    ) u_addr (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .advance     (issue),
        .if_len      (if_len),
        .filter_len  (filter_len),
        .if_raddr    (if_raddr),
        .filter_raddr(filter_raddr),
        .last_tap    (last_tap),
        .last_win    (last_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            v1    <= 1'b0;
            v2    <= 1'b0;
            par1  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= degenerate ? FINISH : ISSUE;
                ISSUE:   if (issue && last_tap && last_win) state <= DRAIN;
                DRAIN:   if (!pipe_stall && !v1) state <= FINISH;
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
            // A stall freezes the whole valid pipeline so nothing is lost or repeated.
            if (!pipe_stall) begin
                v1   <= (state == ISSUE);
                par1 <= (state == ISSUE) && last_tap;
                v2   <= v1;
            end
        end
    end

    assign if_ren     = issue;
    assign filter_ren = issue;
    assign if_out     = if_rdata;
    assign filter_out = filter_rdata;
    assign ld_mult    = v1 && !pipe_stall;
    assign ld_add     = v2 && !pipe_stall;
    assign par_done   = par1 && !pipe_stall;
    assign busy       = (state == ISSUE) || (state == DRAIN);
    assign done       = (state == FINISH);

`ifdef PIPE_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cnt <= '0;
        end else if (busy && pipe_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end
`endif

endmodule
